// File: rtl/grid_claim_arbiter_pkg.sv
// Shared placement definitions: empty-cell marker, grid opcodes and the
// arbiter state encoding used by the grid claim arbiter.
package placement_pkg;

    // Marker stored in a grid cell that holds no node (32-bit grid words).
    localparam logic [31:0] EMPTY_CELL = 32'hFFFF_FFFF;

    // Engine opcodes; 2'b11 is not listed and is treated as a read.
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_CLAIM = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/grid_claim_arbiter_if.sv
// Bundle of the engine request bus and the grid RAM port seen by the arbiter.
// master: engines plus RAM environment; slave: the arbiter itself.
interface grid_claim_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]        req;
    logic [2*N_REQ-1:0]      op;
    logic [ADDR_W*N_REQ-1:0] addr;
    logic [DATA_W*N_REQ-1:0] wdata;
    logic [N_REQ-1:0]        done;
    logic [DATA_W-1:0]       rdata;
    logic                    claim_ok;
    logic                    busy;
    logic                    mem_re;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem_rdata;

    modport master (
        output req, op, addr, wdata, mem_rdata,
        input  done, rdata, claim_ok, busy, mem_re, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req, op, addr, wdata, mem_rdata,
        output done, rdata, claim_ok, busy, mem_re, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/grid_claim_arbiter_rr_pick.sv
// Round-robin pick: rotate the request vector so that bit ptr lands at
// position 0, take the lowest set bit, and map it back to an engine index.
module rr_pick #(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    logic [2*N_REQ-1:0] dbl_s;
    logic [N_REQ-1:0]   rot_s;
    logic [IDX_W-1:0]   off_s;
    logic [IDX_W:0]     sum_s;

    // Rotate, priority-encode the lowest request, and wrap the offset back to an id.
    always_comb begin
        dbl_s = {req, req} >> ptr;
        rot_s = dbl_s[N_REQ-1:0];
        off_s = {IDX_W{1'b0}};
        for (int i = N_REQ - 1; i >= 0; i--) begin
            off_s = rot_s[i] ? IDX_W'(i) : off_s;
        end
        sum_s = {1'b0, ptr} + {1'b0, off_s};
        if (sum_s >= (IDX_W + 1)'(N_REQ)) begin
            winner = IDX_W'(sum_s - (IDX_W + 1)'(N_REQ));
        end else begin
            winner = sum_s[IDX_W-1:0];
        end
        any_req = |req;
    end

endmodule

// File: rtl/grid_claim_arbiter.sv
// Round-robin arbiter sharing one grid RAM between placement engines.
// Claims are read-check-write with no other RAM access in between, so two
// engines can never place nodes on the same cell.
module grid_claim_arbiter
    import placement_pkg::*;
#(
    parameter int                N_REQ  = 4,
    parameter int                ADDR_W = 12,
    parameter int                DATA_W = 32,
    parameter logic [DATA_W-1:0] EMPTY  = {DATA_W{1'b1}}
) (
    input logic                 clk,
    input logic                 reset,
    grid_claim_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_t        state_r, state_s;
    logic [IDX_W-1:0]  ptr_r, ptr_s, id_r, winner_s;
    logic              any_req_s;
    logic [1:0]        op_r, sel_op_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    logic [N_REQ-1:0]  done_r, done_s;
    logic [DATA_W-1:0] rdata_r, rdata_s;
    logic              claim_ok_r, claim_ok_s;
    logic              busy_r, busy_s;
    logic              mem_re_r, mem_re_s;
    logic              mem_we_r, mem_we_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req     (bus.req),
        .ptr     (ptr_r),
        .winner  (winner_s),
        .any_req (any_req_s)
    );

    // Operands of the engine the picker currently favours.
    always_comb begin
        sel_op_s    = bus.op[{winner_s, 1'b0} +: 2];
        sel_addr_s  = bus.addr[winner_s*ADDR_W +: ADDR_W];
        sel_wdata_s = bus.wdata[winner_s*DATA_W +: DATA_W];
        if (id_r == IDX_W'(N_REQ - 1)) begin
            ptr_s = {IDX_W{1'b0}};
        end else begin
            ptr_s = id_r + IDX_W'(1);
        end
    end

    // State register; reset overrides any in-flight transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (op_r == OP_WRITE) begin
                    state_s = DONE;
                end else begin
                    state_s = WAIT;
                end
            end
            WAIT:    state_s = CHECK;
            CHECK:   state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Latch the granted engine and advance the round-robin pointer on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r <= {IDX_W{1'b0}};
            id_r  <= {IDX_W{1'b0}};
            op_r  <= OP_READ;
        end else begin
            if (state_r == IDLE && any_req_s) begin
                id_r <= winner_s;
                op_r <= sel_op_s;
            end
            if (state_s == DONE) begin
                ptr_r <= ptr_s;
            end
        end
    end

    // Output values for the state being entered; they are registered below so
    // every output is a flop that lines up with the state it belongs to.
    always_comb begin
        done_s      = {N_REQ{1'b0}};
        mem_re_s    = 1'b0;
        mem_we_s    = 1'b0;
        rdata_s     = rdata_r;
        claim_ok_s  = claim_ok_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        busy_s      = (state_s != IDLE);
        case (state_s)
            ISSUE: begin
                mem_addr_s  = sel_addr_s;
                mem_wdata_s = sel_wdata_s;
                claim_ok_s  = 1'b0;
                if (sel_op_s == OP_WRITE) begin
                    mem_we_s = 1'b1;
                end else begin
                    mem_re_s = 1'b1;
                end
            end
            CHECK: begin
                rdata_s = bus.mem_rdata;
                if (op_r == OP_CLAIM && bus.mem_rdata == EMPTY) begin
                    mem_we_s   = 1'b1;
                    claim_ok_s = 1'b1;
                end else begin
                    claim_ok_s = 1'b0;
                end
            end
            DONE: begin
                done_s[id_r] = 1'b1;
            end
            default: begin
                done_s = {N_REQ{1'b0}};
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_r      <= {N_REQ{1'b0}};
            rdata_r     <= {DATA_W{1'b0}};
            claim_ok_r  <= 1'b0;
            busy_r      <= 1'b0;
            mem_re_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else begin
            done_r      <= done_s;
            rdata_r     <= rdata_s;
            claim_ok_r  <= claim_ok_s;
            busy_r      <= busy_s;
            mem_re_r    <= mem_re_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
        end
    end

    assign bus.done      = done_r;
    assign bus.rdata     = rdata_r;
    assign bus.claim_ok  = claim_ok_r;
    assign bus.busy      = busy_r;
    assign bus.mem_re    = mem_re_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;

endmodule
